// File: rtl/test_port_pkg.sv
// Shared definitions for the test-port tap: per-channel mode encodings and select-width helper.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package test_port_pkg;

    typedef enum logic [1:0] {
        MODE_LEVEL   = 2'd0,
        MODE_EDGE    = 2'd1,
        MODE_STRETCH = 2'd2,
        MODE_STICKY  = 2'd3
    } tap_mode_e;

    // Bit-index width needed to address a w-bit bus; never narrower than one bit.
    function automatic int sel_w(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/test_port_tap_ch.sv
// One tap channel: picks a TstPort bit and shapes it (level/edge/stretch/sticky); optional event counter (TEST_PORT_TAP_CNT_EN).
// Latency: 1 cycle from TstPort to tst_bit.
// Backpressure: none; observes every cycle.
module test_port_tap_ch
    import test_port_pkg::*;
#(
    parameter int W       = 16,
    parameter int STRETCH = 8
`ifdef TEST_PORT_TAP_CNT_EN
    , parameter int CW    = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          tst_port,
    input  logic [sel_w(W)-1:0]   sel,
    input  logic [1:0]            mode,
    input  logic                  clr,
    output logic                  tst_bit
`ifdef TEST_PORT_TAP_CNT_EN
    , output logic [CW-1:0]       evt_cnt
`endif
);

    localparam int STW = $clog2(STRETCH + 1);

    logic [W-1:0]        shifted;
    logic                b;
    logic                mode_chg;
    logic                cfg_chg;
    logic                rise;

    logic                prev_q, prev_d;
    logic [sel_w(W)-1:0] sel_sh_q, sel_sh_d;
    logic [1:0]          mode_sh_q, mode_sh_d;
    logic                post_rst_q, post_rst_d;
    logic [STW-1:0]      cnt_q, cnt_d;
    logic                flag_q, flag_d;
    logic                tbit_q, tbit_d;

    // Bit pick, glitch guard on reconfiguration, and per-mode output shaping.
    always_comb begin
        // A shift past the top of the bus yields 0, so out-of-range indices read as 0.
        shifted    = tst_port >> sel;
        b          = shifted[0];
        mode_chg   = (mode != mode_sh_q);
        cfg_chg    = mode_chg | (sel != sel_sh_q);
        rise       = b & ~prev_q & ~cfg_chg & ~post_rst_q;

        prev_d     = b;
        sel_sh_d   = sel;
        mode_sh_d  = mode;
        post_rst_d = 1'b0;
        cnt_d      = cnt_q;
        flag_d     = flag_q;
        tbit_d     = 1'b0;

        case (tap_mode_e'(mode))
            MODE_LEVEL: tbit_d = b;
            MODE_EDGE:  tbit_d = rise;
            MODE_STRETCH: begin
                if (rise) begin
                    cnt_d = STW'(STRETCH);
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - STW'(1);
                end
                tbit_d = rise | ((cnt_q > STW'(1)) & ~mode_chg);
            end
            MODE_STICKY: begin
                flag_d = rise | (flag_q & ~clr & ~mode_chg);
                tbit_d = flag_d;
            end
            default: tbit_d = 1'b0;
        endcase

        // Entering a new mode always starts from a clean stretch/sticky state.
        if (mode_chg) begin
            cnt_d  = '0;
            flag_d = 1'b0;
        end
    end

    // Channel state registers; reset also captures the current configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= 1'b0;
            sel_sh_q   <= sel;
            mode_sh_q  <= mode;
            post_rst_q <= 1'b1;
            cnt_q      <= '0;
            flag_q     <= 1'b0;
            tbit_q     <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            sel_sh_q   <= sel_sh_d;
            mode_sh_q  <= mode_sh_d;
            post_rst_q <= post_rst_d;
            cnt_q      <= cnt_d;
            flag_q     <= flag_d;
            tbit_q     <= tbit_d;
        end
    end

    assign tst_bit = tbit_q;

`ifdef TEST_PORT_TAP_CNT_EN
    logic [CW-1:0] evt_q, evt_d;

    // Saturating rising-edge count; a clear coinciding with an edge leaves one count.
    always_comb begin
        evt_d = evt_q;
        if (clr) begin
            evt_d = CW'(rise);
        end else if (rise && (evt_q != '1)) begin
            evt_d = evt_q + CW'(1);
        end
    end

    // Event counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign evt_cnt = evt_q;
`endif

endmodule

// File: rtl/test_port_tap.sv
// N independent taps on a W-bit test bus; optional per-channel event counters (TEST_PORT_TAP_CNT_EN).
// Latency: 1 cycle from TstPort to TstBit.
// Backpressure: none; pure observer.
module test_port_tap
    import test_port_pkg::*;
#(
    parameter int W       = 16,
    parameter int N       = 4,
    parameter int STRETCH = 8
`ifdef TEST_PORT_TAP_CNT_EN
    , parameter int CW    = 16
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [W-1:0]            TstPort,
    input  logic [N*sel_w(W)-1:0]   sel,
    input  logic [2*N-1:0]          mode,
    input  logic [N-1:0]            clr,
    output logic [N-1:0]            TstBit
`ifdef TEST_PORT_TAP_CNT_EN
    , output logic [N*CW-1:0]       evt_cnt
`endif
);

    localparam int SELW = sel_w(W);

    for (genvar k = 0; k < N; k++) begin : g_ch
        test_port_tap_ch #(
            .W       (W),
            .STRETCH (STRETCH)
`ifdef TEST_PORT_TAP_CNT_EN
            , .CW    (CW)
`endif
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .tst_port (TstPort),
            .sel      (sel[k*SELW +: SELW]),
            .mode     (mode[2*k +: 2]),
            .clr      (clr[k]),
            .tst_bit  (TstBit[k])
`ifdef TEST_PORT_TAP_CNT_EN
            , .evt_cnt (evt_cnt[k*CW +: CW])
`endif
        );
    end

endmodule

// File: tb/tb_test_port_tap.sv
// Directed bench for test_port_tap: level/edge/stretch/sticky shaping, reconfiguration guard, reset, counters.
// Latency: checks TstBit one edge after the stimulus.
// Backpressure: n/a.
module tb_test_port_tap;
    import test_port_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] TstPort;
    logic [15:0] sel;
    logic [7:0]  mode;
    logic [3:0]  clr;
    logic [3:0]  TstBit;

    logic [11:0] tst2;
    logic [3:0]  sel2;
    logic [1:0]  mode2;
    logic [0:0]  clr2;
    logic [0:0]  bit2;

`ifdef TEST_PORT_TAP_CNT_EN
    logic [15:0] evt_cnt;
    logic [3:0]  evt2;
`endif

    int n_chk;
    int n_pass;

    test_port_tap #(
        .W(16), .N(4), .STRETCH(8)
`ifdef TEST_PORT_TAP_CNT_EN
        , .CW(4)
`endif
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .TstPort (TstPort),
        .sel     (sel),
        .mode    (mode),
        .clr     (clr),
        .TstBit  (TstBit)
`ifdef TEST_PORT_TAP_CNT_EN
        , .evt_cnt (evt_cnt)
`endif
    );

    // Non-power-of-two bus so that indices past the top can be exercised.
    test_port_tap #(
        .W(12), .N(1), .STRETCH(8)
`ifdef TEST_PORT_TAP_CNT_EN
        , .CW(4)
`endif
    ) dut2 (
        .clk     (clk),
        .rst     (rst),
        .TstPort (tst2),
        .sel     (sel2),
        .mode    (mode2),
        .clr     (clr2),
        .TstBit  (bit2)
`ifdef TEST_PORT_TAP_CNT_EN
        , .evt_cnt (evt2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 1'b1; TstPort = '0; sel = '0; mode = '0; clr = '0;
        tst2 = '0; sel2 = '0; mode2 = MODE_LEVEL; clr2 = '0;
        tick(); tick();
        chk("rst_bit", 64'(TstBit), 64'd0);
`ifdef TEST_PORT_TAP_CNT_EN
        chk("rst_cnt", 64'(evt_cnt), 64'd0);
`endif

        // LEVEL on bit 7, configured while in reset.
        sel[3:0] = 4'd7;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            TstPort = (i % 2 == 0) ? 16'h0080 : 16'h0000;
            tick();
            chk("level", 64'(TstBit), 64'(i % 2 == 0));
        end

        // EDGE on bit 3 held high for five cycles.
        TstPort = '0; mode[1:0] = MODE_EDGE; sel[3:0] = 4'd3;
        tick(); tick();
        chk("edge_idle", 64'(TstBit), 64'd0);
        for (int i = 0; i < 6; i++) begin
            TstPort = (i < 5) ? 16'h0008 : 16'h0000;
            tick();
            chk("edge", 64'(TstBit), 64'(i == 0));
        end

        // Bit already high when reset drops: no edge in the first cycle.
        rst = 1'b1; TstPort = 16'h0008;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_rise", 64'(TstBit), 64'd0);
        tick();
        chk("post_rst_hold", 64'(TstBit), 64'd0);

        // STRETCH: isolated edge, then edge plus retrigger five cycles later.
        TstPort = '0; mode[1:0] = MODE_STRETCH; sel[3:0] = 4'd2;
        tick(); tick();
        for (int j = 0; j < 12; j++) begin
            TstPort = (j == 0) ? 16'h0004 : 16'h0000;
            tick();
            chk("stretch1", 64'(TstBit), 64'(j < 8));
        end
        for (int j = 0; j < 16; j++) begin
            TstPort = (j == 0 || j == 5) ? 16'h0004 : 16'h0000;
            tick();
            chk("stretch2", 64'(TstBit), 64'(j < 13));
        end

        // Leaving and re-entering STRETCH mid-pulse drops the pulse.
        TstPort = 16'h0004;
        tick();
        chk("stretch_go", 64'(TstBit), 64'd1);
        TstPort = '0; mode[1:0] = MODE_LEVEL;
        tick();
        chk("stretch_leave", 64'(TstBit), 64'd0);
        mode[1:0] = MODE_STRETCH;
        tick();
        chk("stretch_reenter", 64'(TstBit), 64'd0);
        tick();
        chk("stretch_stay_low", 64'(TstBit), 64'd0);

        // STICKY: set, clear ten cycles later; then rise and clear together.
        TstPort = '0; mode[1:0] = MODE_STICKY;
        tick(); tick();
        for (int j = 0; j < 14; j++) begin
            TstPort = (j == 0) ? 16'h0004 : 16'h0000;
            clr[0] = (j == 10);
            tick();
            chk("sticky", 64'(TstBit), 64'(j < 10));
        end
        clr[0] = 1'b0;
        for (int j = 0; j < 5; j++) begin
            TstPort = (j == 2) ? 16'h0004 : 16'h0000;
            clr[0] = (j == 2);
            tick();
            chk("sticky_rise_clr", 64'(TstBit), 64'(j >= 2));
        end
        clr[0] = 1'b1;
        tick();
        chk("sticky_clr", 64'(TstBit), 64'd0);
        clr[0] = 1'b0;

        // Select moved from a low bit to a high bit: no edge, no count.
        TstPort = 16'h0020; mode[1:0] = MODE_EDGE; sel[3:0] = 4'd2; clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        tick();
        chk("sel_idle", 64'(TstBit), 64'd0);
`ifdef TEST_PORT_TAP_CNT_EN
        chk("sel_idle_cnt", 64'(evt_cnt[3:0]), 64'd0);
`endif
        sel[3:0] = 4'd5;
        tick();
        chk("sel_glitch", 64'(TstBit), 64'd0);
        tick();
        chk("sel_glitch_after", 64'(TstBit), 64'd0);
`ifdef TEST_PORT_TAP_CNT_EN
        chk("sel_glitch_cnt", 64'(evt_cnt[3:0]), 64'd0);

        // Twenty edges into a 4-bit counter saturate at 15.
        TstPort = '0; sel[3:0] = 4'd3; clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        for (int e = 0; e < 20; e++) begin
            TstPort = 16'h0008;
            tick();
            TstPort = 16'h0000;
            tick();
            if (e == 9) chk("cnt_10", 64'(evt_cnt[3:0]), 64'd10);
        end
        chk("cnt_sat", 64'(evt_cnt[3:0]), 64'd15);
        chk("cnt_other", 64'(evt_cnt[15:4]), 64'd0);
        TstPort = 16'h0008; clr[0] = 1'b1;
        tick();
        chk("cnt_clr_rise", 64'(evt_cnt[3:0]), 64'd1);
        clr[0] = 1'b0;
`endif

        // Reset lands mid-stretch (ch0) and mid-sticky (ch1).
        TstPort = '0; mode[1:0] = MODE_STRETCH; sel[3:0] = 4'd2;
        mode[3:2] = MODE_STICKY; sel[7:4] = 4'd2;
        tick(); tick();
        TstPort = 16'h0004;
        tick();
        TstPort = '0;
        tick();
        chk("pre_rst", 64'(TstBit), 64'h3);
        rst = 1'b1;
        tick();
        chk("rst_mid", 64'(TstBit), 64'd0);
`ifdef TEST_PORT_TAP_CNT_EN
        chk("rst_mid_cnt", 64'(evt_cnt), 64'd0);
`endif
        rst = 1'b0;
        tick();
        chk("rst_after", 64'(TstBit), 64'd0);

        // Out-of-range select on the 12-bit instance reads as zero.
        tst2 = 12'hFFF; sel2 = 4'd13;
        tick(); tick();
        chk("oob_sel13", 64'(bit2), 64'd0);
        sel2 = 4'd11;
        tick();
        chk("sel11", 64'(bit2), 64'd1);
        sel2 = 4'd12;
        tick();
        chk("oob_sel12", 64'(bit2), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/test_port_tap.md
TEST_PORT_TAP -- requirements
Module: test_port_tap

Interface
REQ-001 SHALL have parameter W, default 16: TstPort width, 2..64.
REQ-002 SHALL have parameter N, default 4: number of independent tap channels, 1..16.
REQ-003 SHALL have parameter STRETCH, default 8: pulse-stretch length in clk cycles, >=1.
REQ-004 SHALL have parameter CW, default 16: event counter width, present only when the counter feature is compiled in.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port TstPort, input, W: observed test bus.
REQ-008 SHALL have port sel, input, N*SELW: per-channel bit index, SELW = clog2(W); channel k uses slice k.
REQ-009 SHALL have port mode, input, 2*N: per-channel mode; 0 LEVEL, 1 EDGE, 2 STRETCH, 3 STICKY.
REQ-010 SHALL have port clr, input, N: per-channel clear for sticky flag and counter.
REQ-011 SHALL have port TstBit, output, N: registered per-channel tap output.
REQ-012 SHALL have port evt_cnt, output, N*CW: per-channel rising-edge count; the port exists only with the counter feature.

Function
REQ-013 SHALL define per channel b = TstPort[sel_k]; an index >= W SHALL read b = 0.
REQ-014 SHALL register b into prev_k every cycle, and SHALL register sel_k and mode_k into shadow registers.
REQ-015 SHALL define rise_k = b & ~prev_k, forced to 0 in any cycle where sel_k or mode_k differs from its shadow value; this forced-0 rule is the glitch guard on reconfiguration.
REQ-016 SHALL, in LEVEL mode, update TstBit_k <= b, giving 1-cycle latency.
REQ-017 SHALL, in EDGE mode, update TstBit_k <= rise_k, producing a one-cycle pulse per rising edge.
REQ-018 SHALL, in STRETCH mode, load the down-counter with STRETCH on rise_k and otherwise decrement it to 0, with TstBit_k <= (rise_k | cnt_k > 1).
  - The output is high for exactly STRETCH cycles after an isolated edge.
  - A retrigger while high reloads the counter and extends the pulse.
REQ-019 SHALL, in STICKY mode, set the flag on rise_k and clear it on clr_k, with TstBit_k <= flag next value.
  - Simultaneous rise_k and clr_k leaves the flag set.
REQ-020 SHALL, on any mode change, clear the stretch counter and sticky flag of that channel in that cycle.
REQ-021 SHALL keep all channels fully independent; one TstPort bit MAY feed several channels.

Reset
REQ-022 SHALL, with rst high at a clock edge, set TstBit, prev, the stretch counters, sticky flags and evt_cnt to 0, and load the shadow sel/mode registers from the current inputs.
REQ-023 SHALL give rst priority over all other inputs, including mid-stretch and mid-sticky.
REQ-024 SHALL suppress rise in the first cycle after reset.

Configuration
REQ-025 SHALL, with macro TEST_PORT_TAP_CNT_EN defined, include per-channel CW-bit counters.
  - A counter increments on rise_k in every mode and saturates at all-ones.
  - clr_k zeroes it; clr_k with a simultaneous rise_k yields 1.
REQ-026 SHALL, without TEST_PORT_TAP_CNT_EN, contain no counter logic and no evt_cnt port.

Structure
REQ-027 SHALL place the mode encodings (LEVEL/EDGE/STRETCH/STICKY) and the SELW derivation function in shared package test_port_pkg.
REQ-028 SHALL implement one channel as sub-module test_port_tap_ch, instanced N times by a generate loop; the top only slices the buses.

Verification
REQ-029 SHALL cover: LEVEL, sel=7, TstPort toggles 0x0080/0x0000 each cycle -> TstBit[0] follows with 1-cycle delay.
REQ-030 SHALL cover: EDGE, TstPort[3] held high 5 cycles -> exactly one 1-cycle pulse, appearing 1 cycle after the rise.
REQ-031 SHALL cover: STRETCH=8, a single-cycle rise -> high for 8 cycles; a second rise at cycle 5 -> high until cycle 13.
REQ-032 SHALL cover: STICKY, rise then clr 10 cycles later -> high from the rise until the cycle after clr; rise+clr together -> stays high.
REQ-033 SHALL cover: sel changed 2->5 while bit5=1 and bit2=0 -> no EDGE pulse and no count increment.
REQ-034 SHALL cover: with TEST_PORT_TAP_CNT_EN and CW=4, 20 edges -> evt_cnt saturates at 15; rst mid-stretch -> all outputs 0 the next cycle.
